data_mem_responder: RTL and testbench

Responder side of the SimpleRisc data-memory interface. It accepts one load or store request at a time from the pipeline's memory-access stage over a valid/ready handshake. It performs a word-aligned access to an internal 32-bit word array after a fixed, parameterised number of wait cycles, then returns read data and status over a second valid/ready handshake. It replaces the zero-latency behavioural array with a clocked memory that has realistic wait states.

---
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_array.sv | 40 ++++
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types, widths and address helpers for the SimpleRisc data-memory responder.
package dmem_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Misaligned, or any address bit above the word index is set.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    logic [ADDR_W-1:0] hi;
    hi = addr >> (idx_w(depth) + ADDR_LSB);
    return (addr[ADDR_LSB-1:0] != '0) || (hi != '0);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the memory-access stage and the responder.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port DEPTH x 32 word array with synchronous write and registered read data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic                     i_clr,
  input  logic [idx_w(DEPTH)-1:0]  i_idx,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Read register holds between accesses; cleared for store/error responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding request, LAT wait cycles, commit on entry to RESP.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned IW = idx_w(DEPTH);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_we;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;

  logic              w_commit;
  logic              w_err;
  logic [IW-1:0]     w_idx;
  logic [DATA_W-1:0] w_rdata;

  assign w_err    = addr_err(r_mar, DEPTH);
  assign w_idx    = r_mar[IW+ADDR_LSB-1:ADDR_LSB];
  assign w_commit = (r_state == WAIT) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_mar        <= '0;
      r_mdr        <= '0;
      r_we         <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_mar       <= bus.req_addr;
            r_mdr       <= bus.req_wdata;
            r_we        <= bus.req_we;
            r_cnt       <= CNT_W'(LAT);
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          // Counter at zero marks the commit edge into RESP.
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_commit && r_we && !w_err),
    .i_re    (w_commit && !r_we && !w_err),
    .i_clr   (w_commit && (r_we || w_err)),
    .i_idx   (w_idx),
    .i_wdata (r_mdr),
    .o_rdata (w_rdata)
  );

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = w_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: two responders (LAT=2 and LAT=0) against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;

  logic clk;
  logic rst_n;

  logic        req_valid  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();

  assign if0.req_valid  = req_valid[0];
  assign if0.req_we     = req_we[0];
  assign if0.req_addr   = req_addr[0];
  assign if0.req_wdata  = req_wdata[0];
  assign if0.resp_ready = resp_ready[0];
  assign req_ready[0]   = if0.req_ready;
  assign resp_valid[0]  = if0.resp_valid;
  assign resp_rdata[0]  = if0.resp_rdata;
  assign resp_err[0]    = if0.resp_err;

  assign if1.req_valid  = req_valid[1];
  assign if1.req_we     = req_we[1];
  assign if1.req_addr   = req_addr[1];
  assign if1.req_wdata  = req_wdata[1];
  assign if1.resp_ready = resp_ready[1];
  assign req_ready[1]   = if1.req_ready;
  assign resp_valid[1]  = if1.resp_valid;
  assign resp_rdata[1]  = if1.resp_rdata;
  assign resp_err[1]    = if1.resp_err;

  data_mem_responder #(.DEPTH(DEPTH), .LAT(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  data_mem_responder #(.DEPTH(DEPTH), .LAT(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit [31:0] mdl   [2][DEPTH];
  bit        known [2][DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit ref_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
  endfunction

  task automatic issue(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    int c;
    c = 0;
    while (req_ready[d] !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  // Returns cycles after the accept edge until resp_valid, or 99 on timeout.
  task automatic wait_resp(input int d, output int c);
    c = 0;
    while (resp_valid[d] !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (c >= 20) c = 99;
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold);
    int c;
    bit e_err;
    bit chk_rd;
    logic [31:0] e_rd;
    logic [31:0] rd0;
    logic        er0;
    e_err  = ref_err(addr);
    chk_rd = 1'b1;
    e_rd   = 32'h0;
    if (!we && !e_err) begin
      if (known[d][addr[11:2]]) e_rd = mdl[d][addr[11:2]];
      else chk_rd = 1'b0;
    end
    issue(d, we, addr, wd);
    check("req_ready_busy", 32'(req_ready[d]), 32'd0);
    wait_resp(d, c);
    check("latency", 32'(c), 32'(lat_of(d) + 1));
    if (c == 99) return;
    check("resp_err", 32'(resp_err[d]), 32'(e_err));
    if (chk_rd) check("resp_rdata", resp_rdata[d], e_rd);
    rd0 = resp_rdata[d];
    er0 = resp_err[d];
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'hBAD0_0000 | 32'(i);
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[d]), 32'd1);
      check("hold_rdata", resp_rdata[d], rd0);
      check("hold_err", 32'(resp_err[d]), 32'(er0));
      check("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("post_valid", 32'(resp_valid[d]), 32'd0);
    check("post_ready", 32'(req_ready[d]), 32'd1);
    if (we && !e_err) begin
      mdl[d][addr[11:2]]   = wd;
      known[d][addr[11:2]] = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_resp_err", 32'(resp_err[d]), 32'd0);
      check("rst_resp_rdata", resp_rdata[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] pool [7];
    int r;
    pool[0] = 32'h0;   pool[1] = 32'h4;   pool[2] = 32'h10;  pool[3] = 32'h20;
    pool[4] = 32'h30;  pool[5] = 32'h100; pool[6] = 32'hFFC;
    r = int'($urandom_range(0, 9));
    if (r < 7) return pool[r];
    if (r == 7) return pool[$urandom_range(0, 6)] | 32'($urandom_range(1, 3));
    if (r == 8) return 32'h1000 + (32'($urandom_range(0, 255)) << 2);
    return $urandom();
  endfunction

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   resp_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    pulse_reset();

    // Directed sequence on the LAT=2 responder.
    txn(0, 1'b1, 32'h0,    32'h1111_1111, 0);
    txn(0, 1'b1, 32'h10,   32'hDEAD_BEEF, 0);
    txn(0, 1'b0, 32'h10,   32'h0,         0);
    txn(0, 1'b0, 32'h13,   32'h0,         0);
    txn(0, 1'b1, 32'h1000, 32'h7777_7777, 0);
    txn(0, 1'b0, 32'h0,    32'h0,         0);
    txn(0, 1'b0, 32'h10,   32'h0,         5);
    txn(0, 1'b0, 32'h0,    32'h0,         0);

    // Reset during WAIT drops an uncommitted store.
    txn(0, 1'b1, 32'h20, 32'h0BAD_CAFE, 0);
    issue(0, 1'b1, 32'h20, 32'hCAFE_F00D);
    @(negedge clk);
    pulse_reset();
    txn(0, 1'b0, 32'h20, 32'h0, 0);

    // Reset during RESP keeps a store that already committed.
    issue(0, 1'b1, 32'h30, 32'h3030_3030);
    wait_resp(0, c);
    check("commit_latency", 32'(c), 32'd3);
    mdl[0][12]   = 32'h3030_3030;
    known[0][12] = 1'b1;
    pulse_reset();
    txn(0, 1'b0, 32'h30, 32'h0, 0);

    txn(0, 1'b1, 32'hFFC, 32'hA5A5_5A5A, 0);
    txn(0, 1'b0, 32'hFFC, 32'h0,         0);

    // LAT=0 responder: single-cycle wait, back-to-back traffic.
    txn(1, 1'b1, 32'h4, 32'h1234_5678, 0);
    txn(1, 1'b0, 32'h4, 32'h0,         0);
    for (int i = 0; i < 6; i++) begin
      txn(1, 1'b1, 32'(i) << 2, 32'hC0DE_0000 | 32'(i), 0);
      txn(1, 1'b0, 32'(i) << 2, 32'h0, 0);
    end
    txn(1, 1'b0, 32'h4, 32'h0, 3);

    // Randomized traffic on both responders.
    for (int i = 0; i < 60; i++) begin
      txn(i % 2, 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
          int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
